cla_pipe_adder32: RTL

CLA_PIPE_ADDER32 -- requirements
Module: cla_pipe_adder32

---
 rtl/cla_pipe_adder32.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder32.sv
// cla_pipe_adder32: two-stage pipelined 32-bit adder/subtractor with two-level
// carry lookahead (8 groups of 4 bits). S1 registers bitwise generate/propagate;
// S2 resolves carries, forms the sum and flags, and drives the outputs. Each stage
// has a valid bit, and stalls propagate backwards through a ready/valid handshake.
module cla_pipe_adder32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        zero
);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic        r_s1_valid;
  logic [31:0] r_s1_p;
  logic [31:0] r_s1_g;
  logic        r_s1_c0;
  logic        r_s1_a31;
  logic        r_s1_b31;

  logic        r_s2_valid;
  logic [31:0] r_s2_sum;
  logic        r_s2_cout;
  logic        r_s2_ovf;
  logic        r_s2_zero;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic        w_s1_load;
  logic        w_s2_load;
  logic [31:0] w_b_eff;
  logic [31:0] w_p_in;
  logic [31:0] w_g_in;
  logic [7:0]  w_grp_g;
  logic [7:0]  w_grp_p;
  logic [8:0]  w_grp_cin;
  logic [31:0] w_carry;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_ovf;
  logic        w_zero;

  // ---------------------------------------------------------------------------
  // Handshake: downstream-driven load enables; in_ready never looks at in_valid
  // ---------------------------------------------------------------------------
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // ---------------------------------------------------------------------------
  // Operand preconditioning: subtraction is A + ~B + 1
  // ---------------------------------------------------------------------------
  assign w_b_eff = sub ? ~b : b;
  assign w_p_in  = a ^ w_b_eff;
  assign w_g_in  = a & w_b_eff;

  // Register S1: bitwise p/g, carry-in and sign bits; valid clears when drained
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_c0    <= 1'b0;
      r_s1_a31   <= 1'b0;
      r_s1_b31   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_p   <= w_p_in;
        r_s1_g   <= w_g_in;
        r_s1_c0  <= sub;
        r_s1_a31 <= a[31];
        r_s1_b31 <= w_b_eff[31];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First lookahead level: group generate/propagate for each 4-bit group
  // ---------------------------------------------------------------------------
  // Form group (G,P) pairs from the registered bitwise p/g
  always_comb begin
    w_grp_g = '0;
    w_grp_p = '0;
    for (int gi = 0; gi < 8; gi++) begin
      w_grp_p[gi] = r_s1_p[4*gi+3] & r_s1_p[4*gi+2] & r_s1_p[4*gi+1] & r_s1_p[4*gi];
      w_grp_g[gi] = r_s1_g[4*gi+3]
                  | (r_s1_p[4*gi+3] & r_s1_g[4*gi+2])
                  | (r_s1_p[4*gi+3] & r_s1_p[4*gi+2] & r_s1_g[4*gi+1])
                  | (r_s1_p[4*gi+3] & r_s1_p[4*gi+2] & r_s1_p[4*gi+1] & r_s1_g[4*gi]);
    end
  end

  // ---------------------------------------------------------------------------
  // Second lookahead level: every group carry-in as a flat sum of products of
  // group (G,P) and c0, so no carry ripples from group to group.
  // ---------------------------------------------------------------------------
  // Expand C[i] = G[i-1] | P[i-1]G[i-2] | ... | P[i-1..0]c0 for i = 1..8
  always_comb begin : proc_grp_carry
    logic v_c;
    logic v_term;
    w_grp_cin    = '0;
    w_grp_cin[0] = r_s1_c0;
    v_c          = 1'b0;
    v_term       = 1'b0;
    for (int ci = 1; ci <= 8; ci++) begin
      v_c = r_s1_c0;
      for (int k = 0; k < ci; k++) begin
        v_c = v_c & w_grp_p[k];
      end
      for (int j = 0; j < ci; j++) begin
        v_term = w_grp_g[j];
        for (int k = j + 1; k < ci; k++) begin
          v_term = v_term & w_grp_p[k];
        end
        v_c = v_c | v_term;
      end
      w_grp_cin[ci] = v_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Intra-group carries c1..c3 from each group carry-in, then sum and flags
  // ---------------------------------------------------------------------------
  // Resolve per-bit carries inside each group and derive the result flags
  always_comb begin : proc_bit_carry
    logic v_cin;
    w_carry = '0;
    v_cin   = 1'b0;
    for (int gi = 0; gi < 8; gi++) begin
      v_cin = w_grp_cin[gi];
      w_carry[4*gi]   = v_cin;
      w_carry[4*gi+1] = r_s1_g[4*gi] | (r_s1_p[4*gi] & v_cin);
      w_carry[4*gi+2] = r_s1_g[4*gi+1]
                      | (r_s1_p[4*gi+1] & r_s1_g[4*gi])
                      | (r_s1_p[4*gi+1] & r_s1_p[4*gi] & v_cin);
      w_carry[4*gi+3] = r_s1_g[4*gi+2]
                      | (r_s1_p[4*gi+2] & r_s1_g[4*gi+1])
                      | (r_s1_p[4*gi+2] & r_s1_p[4*gi+1] & r_s1_g[4*gi])
                      | (r_s1_p[4*gi+2] & r_s1_p[4*gi+1] & r_s1_p[4*gi] & v_cin);
    end
    w_sum  = r_s1_p ^ w_carry;
    w_cout = w_grp_cin[8];
    // Overflow: same-signed operands whose result sign differs from them
    w_ovf  = (r_s1_a31 == r_s1_b31) && (w_sum[31] != r_s1_a31);
    w_zero = (w_sum == 32'h0);
  end

  // Register S2: the result held on the outputs until the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_cout  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_zero  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum  <= w_sum;
        r_s2_cout <= w_cout;
        r_s2_ovf  <= w_ovf;
        r_s2_zero <= w_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = r_s2_valid;
  assign sum       = r_s2_sum;
  assign cout      = r_s2_cout;
  assign ovf       = r_s2_ovf;
  assign zero      = r_s2_zero;

endmodule
